mod_key_expander: RTL and testbench

- Writer side of the round-key store: runs the AES-256 key schedule (FIPS-197, Nk=8, Nr=14) on a 256-bit cipher key.
- Writes the 15 resulting 128-bit round keys, addresses 0..14, into the key RAM that the addRK stage reads by round number.
- SubWord is done through an external shared S-box port (32-bit, fixed latency), so the block holds no S-box table.

---
 rtl/mod_key_expander.sv | 162 ++++++++++++++++
 tb/tb_mod_key_expander.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_key_expander.sv
// mod_key_expander
// Writer side of the round-key store. Runs the AES-256 key schedule
// (Nk=8, Nr=14) on a 256-bit cipher key and writes the 15 round keys
// (addresses 0..14) into the key RAM. SubWord goes through an external
// shared S-box port with a fixed latency of SBOX_LAT cycles.
//
// Ports:
//   clk, resetn      clock (rising edge), asynchronous active-low reset
//   start, key_in    one-cycle request and cipher key (w0 in key_in[255:224])
//   busy, done       run in progress / one-cycle pulse with the rk14 write
//   wr_en, wr_addr,  key-store write port; wr_data = {w[4r]..w[4r+3]}
//   wr_data
//   sbox_in,sbox_out external S-box request word / substituted word
//
// Build macro KEY_ZEROIZE_EN: clears the working registers after the run
// and drives wr_addr/wr_data to zero on every cycle without a write.
module mod_key_expander #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned SBOX_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [255:0]          key_in,
    output logic                  busy,
    output logic                  done,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [31:0]           sbox_in,
    input  logic [31:0]           sbox_out
);

    typedef enum logic [1:0] {IDLE, INIT0, INIT1, EXPAND} state_t;

    localparam logic [5:0]  FIRST_IDX = 6'd8;
    localparam logic [5:0]  LAST_IDX  = 6'd60;
    localparam int unsigned CW        = $clog2(SBOX_LAT + 1);

    state_t        state, state_nx;
    logic [31:0]   win [8];     // win[0] = w[i-8] ... win[7] = w[i-1]
    logic [5:0]    widx;        // index i of the word being computed
    logic [7:0]    rcon;
    logic [CW-1:0] subcnt;      // cycles spent on the current SubWord word

    logic          is_sub, is_rot, in_step, step_done;
    logic [31:0]   temp, new_w;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    // Next-state logic; EXPAND lingers one cycle at i=60 for the rk14 write
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = INIT0;
            INIT0:   state_nx = INIT1;
            INIT1:   state_nx = EXPAND;
            EXPAND:  if (widx == LAST_IDX) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Word computation
    always_comb begin
        is_sub    = (widx[1:0] == 2'b00);
        is_rot    = (widx[2:0] == 3'b000);
        in_step   = (state == EXPAND) && (widx != LAST_IDX);
        // SubWord words wait until sbox_out has caught up with sbox_in
        step_done = in_step && (!is_sub || (subcnt == CW'(SBOX_LAT)));
        if (is_rot)      temp = sbox_out ^ {rcon, 24'h0};
        else if (is_sub) temp = sbox_out;
        else             temp = win[7];
        new_w = win[0] ^ temp;
    end

    // Outputs derived from state
    always_comb begin
        busy    = (state != IDLE);
        sbox_in = '0;
        if (in_step && is_sub) begin
            sbox_in = is_rot ? {win[7][23:0], win[7][31:24]} : win[7];
        end
    end

    // Datapath and registered write port
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            win     <= '{default: '0};
            widx    <= '0;
            rcon    <= '0;
            subcnt  <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            done    <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
`ifdef KEY_ZEROIZE_EN
            wr_addr <= '0;
            wr_data <= '0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int unsigned k = 0; k < 8; k++) begin
                            win[k] <= key_in[255 - 32*k -: 32];
                        end
                        widx    <= FIRST_IDX;
                        rcon    <= 8'h01;
                        subcnt  <= '0;
                        wr_en   <= 1'b1;
                        wr_addr <= '0;
                        wr_data <= DATA_WIDTH'(key_in[255:128]);
                    end
                end
                INIT0: begin
                    wr_en   <= 1'b1;
                    wr_addr <= ADDR_WIDTH'(1);
                    wr_data <= DATA_WIDTH'({win[4], win[5], win[6], win[7]});
                end
                INIT1: begin
                end
                EXPAND: begin
                    if (widx == LAST_IDX) begin
`ifdef KEY_ZEROIZE_EN
                        win  <= '{default: '0};
                        rcon <= '0;
`endif
                    end else if (step_done) begin
                        for (int unsigned k = 0; k < 7; k++) begin
                            win[k] <= win[k+1];
                        end
                        win[7] <= new_w;
                        widx   <= widx + 6'd1;
                        subcnt <= '0;
                        if (is_rot) begin
                            rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                        end
                        // w[4r+3] completes round key r: publish it next cycle
                        if (widx[1:0] == 2'b11) begin
                            wr_en   <= 1'b1;
                            wr_addr <= ADDR_WIDTH'(widx[5:2]);
                            wr_data <= DATA_WIDTH'({win[5], win[6], win[7], new_w});
                            done    <= (widx == LAST_IDX - 6'd1);
                        end
                    end else begin
                        subcnt <= subcnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_key_expander.sv
module tb_mod_key_expander;

    localparam logic [255:0] KEY_A =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [255:0] KEY_B =
        256'h0123456789abcdeffedcba9876543210a5a5a5a55a5a5a5a0f0f0f0ff0f0f0f0;
    localparam logic [127:0] RK0_A  = 128'h603deb1015ca71be2b73aef0857d7781;
    localparam logic [127:0] RK1_A  = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] RK2_A  = 128'h9ba354118e6925afa51a8b5f2067fcde;
    localparam logic [127:0] RK14_A = 128'hfe4890d1e6188d0b046df344706c631e;
    localparam logic [127:0] RK2_Z  = 128'h62636363626363636263636362636363;

    logic         clk = 1'b0;
    logic         resetn, start;
    logic [255:0] key_in;

    logic         busy1, done1, wr_en1;
    logic [3:0]   wr_addr1;
    logic [127:0] wr_data1;
    logic [31:0]  sbox_in1, sbox_out1;
    logic         busy3, done3, wr_en3;
    logic [3:0]   wr_addr3;
    logic [127:0] wr_data3;
    logic [31:0]  sbox_in3, sbox_out3;

    int n_total = 0;
    int n_bad   = 0;
    int cnt     = 0;
    int t0      = 0;

    logic [7:0]   sbox_tab [256];
    logic [127:0] exp_rk [15];
    logic [127:0] ks [15];

    mod_key_expander #(.DATA_WIDTH(128), .ADDR_WIDTH(4), .SBOX_LAT(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .start(start), .key_in(key_in),
        .busy(busy1), .done(done1), .wr_en(wr_en1), .wr_addr(wr_addr1),
        .wr_data(wr_data1), .sbox_in(sbox_in1), .sbox_out(sbox_out1)
    );

    mod_key_expander #(.DATA_WIDTH(128), .ADDR_WIDTH(4), .SBOX_LAT(3)) u_dut3 (
        .clk(clk), .resetn(resetn), .start(start), .key_in(key_in),
        .busy(busy3), .done(done3), .wr_en(wr_en3), .wr_addr(wr_addr3),
        .wr_data(wr_data3), .sbox_in(sbox_in3), .sbox_out(sbox_out3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cnt <= cnt + 1;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = '0; x = a; y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] v;
        v = 8'h01;
        for (int k = 0; k < 254; k++) v = gf_mul(v, a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    initial begin
        for (int k = 0; k < 256; k++) sbox_tab[k] = sbox_calc(8'(k));
    end

    // External S-box models with the matching latency
    logic [31:0] sb1;
    logic [31:0] sb3 [3];
    always @(posedge clk) sb1 <= subword(sbox_in1);
    always @(posedge clk) begin
        sb3[0] <= subword(sbox_in3);
        sb3[1] <= sb3[0];
        sb3[2] <= sb3[1];
    end
    assign sbox_out1 = sb1;
    assign sbox_out3 = sb3[2];

    // Write-port loggers
    logic [3:0]   m1_addr [256];
    logic [127:0] m1_data [256];
    logic [3:0]   m3_addr [256];
    logic [127:0] m3_data [256];
    int m1_n = 0, m3_n = 0, m1_b2b = 0, m3_b2b = 0, m1_orphan = 0, m1_leak = 0;
    logic m1_prev = 1'b0, m3_prev = 1'b0;

    always @(negedge clk) begin
        if (wr_en1) begin
            m1_addr[m1_n] <= wr_addr1;
            m1_data[m1_n] <= wr_data1;
            m1_n <= m1_n + 1;
        end
        if (wr_en1 && m1_prev && wr_addr1 != 4'd1) m1_b2b <= m1_b2b + 1;
        if (done1 && !wr_en1) m1_orphan <= m1_orphan + 1;
        if (resetn && !wr_en1 && (wr_addr1 != '0 || wr_data1 != '0)) m1_leak <= m1_leak + 1;
        m1_prev <= wr_en1;
    end

    always @(negedge clk) begin
        if (wr_en3) begin
            m3_addr[m3_n] <= wr_addr3;
            m3_data[m3_n] <= wr_data3;
            m3_n <= m3_n + 1;
        end
        if (wr_en3 && m3_prev && wr_addr3 != 4'd1) m3_b2b <= m3_b2b + 1;
        m3_prev <= wr_en3;
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic build_ref(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int k = 0; k < 8; k++) w[k] = key[255 - 32*k -: 32];
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                t = subword(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic at_cycle(input int k);
        do @(negedge clk); while (cnt < t0 + k);
    endtask

    task automatic begin_run(input logic [255:0] key);
        @(posedge clk); #1;
        t0 = cnt;
        start = 1'b1; key_in = key;
        @(posedge clk); #1;
        start = 1'b0; key_in = KEY_B ^ key;
    endtask

    // Checks one run's log and the key store rebuilt from it
    task automatic check_log(input string nm, input int dut, input int base);
        int n;
        logic [3:0]   a;
        logic [127:0] d;
        n = (dut == 1) ? m1_n : m3_n;
        check_val({nm, "_nwrites"}, 128'(n - base), 128'd15);
        for (int k = 0; k < 15; k++) ks[k] = 'x;
        for (int k = 0; k < 15; k++) begin
            a = (dut == 1) ? m1_addr[base + k] : m3_addr[base + k];
            d = (dut == 1) ? m1_data[base + k] : m3_data[base + k];
            check_val($sformatf("%s_order%0d", nm, k), 128'(a), 128'(k));
            ks[a] = d;
        end
        for (int k = 0; k < 15; k++) begin
            check_val($sformatf("%s_ks%0d", nm, k), ks[k], exp_rk[k]);
        end
    endtask

    int base1, base3, nbefore;
    logic win_or;

    initial begin
        resetn = 1'b0; start = 1'b0; key_in = '0;
        #2;
        check_val("rst_busy",  128'(busy1),    128'd0);
        check_val("rst_done",  128'(done1),    128'd0);
        check_val("rst_wren",  128'(wr_en1),   128'd0);
        check_val("rst_waddr", 128'(wr_addr1), 128'd0);
        check_val("rst_wdata", wr_data1,       128'd0);
        check_val("rst_sbox",  128'(sbox_in1), 128'd0);
        @(negedge clk); @(negedge clk);
        resetn = 1'b1;
        build_ref(KEY_A);

        // FIPS-197 A.3 key on both latencies, with a stray start at cycle 20
        base1 = m1_n; base3 = m3_n;
        begin_run(KEY_A);
        at_cycle(1);
        check_val("c1_wren",  128'(wr_en1),   128'd1);
        check_val("c1_addr",  128'(wr_addr1), 128'd0);
        check_val("c1_data",  wr_data1,       RK0_A);
        check_val("c1_busy",  128'(busy1),    128'd1);
        check_val("c1_sbox",  128'(sbox_in1), 128'd0);
        at_cycle(2);
        check_val("c2_addr",  128'(wr_addr1), 128'd1);
        check_val("c2_data",  wr_data1,       RK1_A);
        at_cycle(3);
        check_val("c3_wren",  128'(wr_en1),   128'd0);
        check_val("c3_sbox",  128'(sbox_in1), 128'h14dff409);
`ifdef KEY_ZEROIZE_EN
        check_val("c3_addr_zero", 128'(wr_addr1), 128'd0);
        check_val("c3_data_zero", wr_data1,       128'd0);
`else
        check_val("c3_addr_hold", 128'(wr_addr1), 128'd1);
        check_val("c3_data_hold", wr_data1,       RK1_A);
`endif
        at_cycle(5);
        check_val("c5_sbox",  128'(sbox_in1), 128'd0);
        at_cycle(20);
        start = 1'b1; key_in = KEY_B;
        at_cycle(21);
        start = 1'b0;
        at_cycle(68);
        check_val("c68_wren", 128'(wr_en1),   128'd1);
        check_val("c68_done", 128'(done1),    128'd1);
        check_val("c68_addr", 128'(wr_addr1), 128'd14);
        check_val("c68_data", wr_data1,       RK14_A);
        check_val("c68_busy", 128'(busy1),    128'd1);
        at_cycle(69);
        check_val("c69_busy", 128'(busy1),    128'd0);
        check_val("c69_done", 128'(done1),    128'd0);
        win_or = 1'b0;
        for (int k = 0; k < 8; k++) win_or = win_or | (|u_dut1.win[k]);
`ifdef KEY_ZEROIZE_EN
        check_val("c69_data_zero", wr_data1,     128'd0);
        check_val("c69_addr_zero", 128'(wr_addr1), 128'd0);
        check_val("c69_win_zero",  128'(win_or), 128'd0);
`else
        check_val("c69_data_hold", wr_data1,     RK14_A);
        check_val("c69_win7_hold", 128'(u_dut1.win[7]), 128'h706c631e);
`endif
        check_val("c69_busy3", 128'(busy3), 128'd1);
        at_cycle(93);
        check_val("c93_done3", 128'(done3), 128'd0);
        at_cycle(94);
        check_val("c94_done3", 128'(done3),    128'd1);
        check_val("c94_addr3", 128'(wr_addr3), 128'd14);
        check_val("c94_data3", wr_data3,       RK14_A);
        at_cycle(95);
        check_val("c95_busy3", 128'(busy3), 128'd0);
        check_log("lat1", 1, base1);
        check_log("lat3", 3, base3);
        check_val("lat1_rk0",  m1_data[base1],      RK0_A);
        check_val("lat1_rk2",  m1_data[base1 + 2],  RK2_A);
        check_val("lat1_rk14", m1_data[base1 + 14], RK14_A);
        check_val("lat3_rk2",  m3_data[base3 + 2],  RK2_A);

        // Asynchronous reset mid-EXPAND, then all-zero key
        begin_run(KEY_A);
        at_cycle(30);
        #2;
        nbefore = m1_n;
        resetn = 1'b0;
        #1;
        check_val("arst_busy",  128'(busy1),    128'd0);
        check_val("arst_done",  128'(done1),    128'd0);
        check_val("arst_wren",  128'(wr_en1),   128'd0);
        check_val("arst_waddr", 128'(wr_addr1), 128'd0);
        check_val("arst_wdata", wr_data1,       128'd0);
        check_val("arst_sbox",  128'(sbox_in1), 128'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check_val("arst_nowrites", 128'(m1_n - nbefore), 128'd0);
        check_val("arst_idle",     128'(busy1),          128'd0);

        build_ref('0);
        base1 = m1_n; base3 = m3_n;
        begin_run('0);
        at_cycle(96);
        check_log("zero1", 1, base1);
        check_log("zero3", 3, base3);
        check_val("zero_rk1", m1_data[base1 + 1], 128'd0);
        check_val("zero_rk2", m1_data[base1 + 2], RK2_Z);

        check_val("b2b1",   128'(m1_b2b),    128'd0);
        check_val("b2b3",   128'(m3_b2b),    128'd0);
        check_val("orphan", 128'(m1_orphan), 128'd0);
`ifdef KEY_ZEROIZE_EN
        check_val("leak", 128'(m1_leak), 128'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
